vend_ctrl_p: RTL and testbench
==============================

Name: vend_ctrl_p

Overview:
- Parametrised successor of the candy-machine control FSM. Controller and credit datapath are merged into one block.
- Adds configurable coin values, price and credit ceiling, coin accept/reject reporting, cancel/refund, an inactivity timeout, and automatic change return over a valid/ready handshake.
- Sits between the coin-slot front end and the product-release and change-dispenser actuators.

Parameters:
- CREDIT_W, 8, width of the credit register.
- COIN1, 10, value of coin code 2'b01.
- COIN2, 20, value of coin code 2'b10.
- COIN3, 50, value of coin code 2'b11.
- PRICE, 80, product price.
- MAX_CREDIT, 150, highest credit accepted. A coin that would exceed it is rejected.
- TIMEOUT, 1000, idle cycles with nonzero credit before an automatic refund. 0 disables the timeout.
- Constraints, checked at elaboration:
  - COIN2, COIN3, PRICE and MAX_CREDIT are multiples of COIN1.
  - COIN1 < COIN2 < COIN3.
  - MAX_CREDIT < 2^CREDIT_W.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- coin_valid, in, 1, one-cycle pulse: a coin is present.
- coin_sel, in, 2, coin code. 2'b00 is an invalid coin.
- cancel, in, 1, request a refund of the current credit.
- coin_accept, out, 1, registered one-cycle pulse: coin credited.
- coin_reject, out, 1, registered one-cycle pulse: coin returned.
- vend, out, 1, one-cycle product-release pulse.
- chg_valid, out, 1, change coin requested.
- chg_sel, out, 2, code of the change coin. Stable while chg_valid is high.
- chg_ready, in, 1, dispenser has taken the coin.
- credit, out, CREDIT_W, current credit.
- busy, out, 1, high whenever state is not WAIT.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = INIT, credit = 0, timer = 0.
  - coin_accept, coin_reject, vend and chg_valid are 0. chg_sel = 0.
- Sum width: all adds are computed in CREDIT_W+1 bits. Subtractions never underflow given the constraints.
- INIT: one cycle, credit cleared, then WAIT.
- WAIT, priority order:
  1. credit >= PRICE -> VEND.
  2. cancel && credit > 0 -> CHANGE.
  3. coin_valid:
     - Reject if coin_sel = 00 or credit + value > MAX_CREDIT. coin_reject pulses on the next cycle.
     - Otherwise credit <= credit + value. coin_accept pulses on the next cycle. Timer cleared.
  4. TIMEOUT != 0, credit > 0, timer reaches TIMEOUT-1 -> CHANGE (automatic refund).
- Timer rules:
  - Increments in WAIT while credit > 0 and no coin is accepted.
  - Cleared on an accepted coin and whenever credit = 0.
- Any coin_valid not accepted is rejected with a coin_reject pulse. This covers coins that lose a priority tie in WAIT and coins arriving in INIT, VEND or CHANGE.
- cancel is ignored outside WAIT.
- VEND:
  - vend = 1 for exactly one cycle. credit <= credit - PRICE.
  - Next state is CHANGE if the remainder > 0, else WAIT.
  - Latency: VEND is entered the cycle after credit first reaches PRICE.
- CHANGE:
  - chg_valid = 1. chg_sel is the largest coin whose value <= credit (11, then 10, then 01). It is derived from registered credit.
  - On chg_valid && chg_ready: credit <= credit - value. If the new credit is 0, go to WAIT with chg_valid = 0 on the next cycle; else stay in CHANGE.
  - chg_valid and chg_sel must not change while chg_ready is low.
- Simultaneous events:
  - credit >= PRICE with a coin: vend wins, coin rejected.
  - cancel with a coin: cancel wins, coin rejected.
  - timeout with an accepted coin: the coin wins and the timer is cleared.
- Reset mid-VEND or mid-CHANGE: immediate return to INIT, outputs drop asynchronously, credit is lost (no refund).
- Illegal state encoding -> INIT.

Decomposition:
- Package vend_pkg holds:
  - State encoding: INIT, WAIT, VEND, CHANGE.
  - Coin code constants: COIN_NONE, COIN_1, COIN_2, COIN_3.
  - Function coin_value(code) -> value.
- One sub-module, vend_timeout: parametrised idle counter.
  - Inputs: clk, rst_n, clr, run.
  - Output: expire pulse.
  - Tied off when TIMEOUT = 0.

Test Plan (defaults unless noted):
- Exact payment: coins 11, 10, 01 (50+20+10) -> three accept pulses, credit 80, vend one cycle later, credit 0, no chg_valid, back to WAIT.
- Overpayment: 11, 11 -> vend, credit 20, chg_valid with chg_sel = 10. chg_ready high -> credit 0, WAIT.
- Handshake stall: after overpayment, hold chg_ready low 5 cycles -> chg_valid stays 1 and chg_sel stays 10 throughout; a coin inserted meanwhile -> coin_reject.
- Cancel: insert 11, 01 (60), pulse cancel -> change 11 then 01, credit 0.
  - In the same run, cancel and coin in the same cycle -> coin_reject and refund.
- Ceiling and invalid coin: MAX_CREDIT = 100. Coins 11, 10 (70), then 11 -> reject, credit stays 70. coin_sel = 00 -> reject.
- Timeout and reset: TIMEOUT = 16. Insert 10, idle 16 cycles -> chg_valid, chg_sel = 10.
  - Separate run: assert rst_n low mid-CHANGE -> chg_valid = 0 immediately, credit 0, INIT on release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared state encoding, coin codes and coin valuation for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_VEND   = 2'b10,
    ST_CHANGE = 2'b11
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  function automatic int unsigned coin_value(input logic [1:0]  code,
                                             input int unsigned v1,
                                             input int unsigned v2,
                                             input int unsigned v3);
    case (code)
      COIN_1:  return v1;
      COIN_2:  return v2;
      COIN_3:  return v3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout.sv
// Idle counter: pulses expire on the TIMEOUT-th consecutive run cycle, then restarts.
module vend_timeout
  import vend_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int unsigned    CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expire = run && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || expire) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vend_ctrl_p.sv
// Vending controller: coin crediting, product release, refund/timeout and change return.
module vend_ctrl_p
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned COIN1      = 10,
  parameter int unsigned COIN2      = 20,
  parameter int unsigned COIN3      = 50,
  parameter int unsigned PRICE      = 80,
  parameter int unsigned MAX_CREDIT = 150,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                cancel,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                vend,
  output logic                chg_valid,
  output logic [1:0]          chg_sel,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if (COIN1 == 0 || (COIN2 % COIN1) != 0 || (COIN3 % COIN1) != 0 ||
      (PRICE % COIN1) != 0 || (MAX_CREDIT % COIN1) != 0) begin : g_bad_multiple
    $error("vend_ctrl_p: COIN2, COIN3, PRICE and MAX_CREDIT must be multiples of COIN1");
  end
  if (!(COIN1 < COIN2 && COIN2 < COIN3)) begin : g_bad_order
    $error("vend_ctrl_p: coin values must satisfy COIN1 < COIN2 < COIN3");
  end
  if ((MAX_CREDIT >> CREDIT_W) != 0) begin : g_bad_ceiling
    $error("vend_ctrl_p: MAX_CREDIT does not fit in CREDIT_W bits");
  end

  typedef logic [CREDIT_W:0] sum_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam sum_t                MAX_C   = sum_t'(MAX_CREDIT);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                accept_q, accept_d;
  logic                reject_q, reject_d;
  logic                vend_q, vend_d;
  logic                chg_valid_q, chg_valid_d;
  logic [1:0]          chg_sel_q, chg_sel_d;

  sum_t                coin_sum;
  logic                coin_ok, accept_now;
  logic [CREDIT_W-1:0] vend_left, chg_left;
  logic                tmr_clr, tmr_run, tmr_expire;

  // Largest coin not exceeding the amount; amounts are always multiples of COIN1.
  function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] amt);
    if ({1'b0, amt} >= sum_t'(COIN3)) return COIN_3;
    if ({1'b0, amt} >= sum_t'(COIN2)) return COIN_2;
    if ({1'b0, amt} >= sum_t'(COIN1)) return COIN_1;
    return COIN_NONE;
  endfunction

  assign coin_sum  = {1'b0, credit_q} + sum_t'(coin_value(coin_sel, COIN1, COIN2, COIN3));
  assign coin_ok   = (coin_sel != COIN_NONE) && (coin_sum <= MAX_C);
  assign vend_left = credit_q - PRICE_C;
  assign chg_left  = credit_q - CREDIT_W'(coin_value(chg_sel_q, COIN1, COIN2, COIN3));

  // A coin is credited only when no higher-priority WAIT event claims the cycle.
  assign accept_now = (state_q == ST_WAIT) && (credit_q < PRICE_C) &&
                      !(cancel && credit_q != '0) && coin_valid && coin_ok;
  assign tmr_clr    = accept_now || (credit_q == '0);
  assign tmr_run    = (state_q == ST_WAIT) && (credit_q != '0) && !accept_now;

  if (TIMEOUT == 0) begin : g_no_timeout
    assign tmr_expire = 1'b0;
  end else begin : g_timeout
    vend_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (tmr_clr),
      .run    (tmr_run),
      .expire (tmr_expire)
    );
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    credit_d    = credit_q;
    accept_d    = 1'b0;
    reject_d    = coin_valid;
    vend_d      = 1'b0;
    chg_valid_d = 1'b0;
    chg_sel_d   = COIN_NONE;

    case (state_q)
      ST_INIT: begin
        credit_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (credit_q >= PRICE_C) begin
          state_d = ST_VEND;
          vend_d  = 1'b1;
        end else if (cancel && credit_q != '0) begin
          state_d     = ST_CHANGE;
          chg_valid_d = 1'b1;
          chg_sel_d   = pick_coin(credit_q);
        end else if (accept_now) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          accept_d = 1'b1;
          reject_d = 1'b0;
        end else if (tmr_expire) begin
          state_d     = ST_CHANGE;
          chg_valid_d = 1'b1;
          chg_sel_d   = pick_coin(credit_q);
        end
      end
      ST_VEND: begin
        credit_d = vend_left;
        if (vend_left != '0) begin
          state_d     = ST_CHANGE;
          chg_valid_d = 1'b1;
          chg_sel_d   = pick_coin(vend_left);
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_CHANGE: begin
        chg_valid_d = 1'b1;
        chg_sel_d   = chg_sel_q;
        if (chg_ready) begin
          credit_d = chg_left;
          if (chg_left == '0) begin
            state_d     = ST_WAIT;
            chg_valid_d = 1'b0;
            chg_sel_d   = COIN_NONE;
          end else begin
            chg_sel_d = pick_coin(chg_left);
          end
        end
      end
      default: begin
        state_d  = ST_INIT;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      credit_q    <= '0;
      accept_q    <= 1'b0;
      reject_q    <= 1'b0;
      vend_q      <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_sel_q   <= COIN_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      credit_q    <= credit_d;
      accept_q    <= accept_d;
      reject_q    <= reject_d;
      vend_q      <= vend_d;
      chg_valid_q <= chg_valid_d;
      chg_sel_q   <= chg_sel_d;
    end
  end

  assign coin_accept = accept_q;
  assign coin_reject = reject_q;
  assign vend        = vend_q;
  assign chg_valid   = chg_valid_q;
  assign chg_sel     = chg_sel_q;
  assign credit      = credit_q;
  assign busy        = (state_q != ST_WAIT);

endmodule

// File: tb/tb_vend_ctrl_p.sv
// Bench for vend_ctrl_p: a default instance and a MAX_CREDIT=100/TIMEOUT=16 instance,
// each compared every cycle against a transaction-level model plus hand-computed spot checks.
module tb_vend_ctrl_p;

  localparam int PH_INIT   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_VEND   = 2;
  localparam int PH_CHANGE = 3;
  localparam int PRICE     = 80;

  int max_credit [2] = '{150, 100};
  int idle_limit [2] = '{1000, 16};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       cv [2];
  logic [1:0] cs [2];
  logic       cn [2];
  logic       cr [2];

  logic       d_acc   [2];
  logic       d_rej   [2];
  logic       d_vend  [2];
  logic       d_cvld  [2];
  logic [1:0] d_csel  [2];
  logic [7:0] d_credit[2];
  logic       d_busy  [2];

  int n_vec  = 0;
  int n_fail = 0;

  // Model state: phase, credit, idle count, registered pulses and the planned change coins.
  int m_phase  [2] = '{PH_INIT, PH_INIT};
  int m_credit [2] = '{0, 0};
  int m_idle   [2] = '{0, 0};
  int m_acc    [2] = '{0, 0};
  int m_rej    [2] = '{0, 0};
  int m_list   [2][8];
  int m_n      [2] = '{0, 0};
  int m_i      [2] = '{0, 0};

  vend_ctrl_p u_dut0 (
    .clk(clk), .rst_n(rst_n), .coin_valid(cv[0]), .coin_sel(cs[0]), .cancel(cn[0]),
    .coin_accept(d_acc[0]), .coin_reject(d_rej[0]), .vend(d_vend[0]),
    .chg_valid(d_cvld[0]), .chg_sel(d_csel[0]), .chg_ready(cr[0]),
    .credit(d_credit[0]), .busy(d_busy[0])
  );

  vend_ctrl_p #(.MAX_CREDIT(100), .TIMEOUT(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .coin_valid(cv[1]), .coin_sel(cs[1]), .cancel(cn[1]),
    .coin_accept(d_acc[1]), .coin_reject(d_rej[1]), .vend(d_vend[1]),
    .chg_valid(d_cvld[1]), .chg_sel(d_csel[1]), .chg_ready(cr[1]),
    .credit(d_credit[1]), .busy(d_busy[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int coin_val(input int code);
    case (code)
      1:       return 10;
      2:       return 20;
      3:       return 50;
      default: return 0;
    endcase
  endfunction

  // Plan the whole refund up front as a greedy list of coins.
  task automatic start_refund(input int k, input int amt);
    int a;
    a = amt;
    m_n[k] = 0;
    while (a > 0 && m_n[k] < 8) begin
      int c;
      c = 3;
      while (c > 0 && coin_val(c) > a) c--;
      m_list[k][m_n[k]] = c;
      m_n[k]++;
      a -= coin_val(c);
    end
    m_i[k]     = 0;
    m_idle[k]  = 0;
    m_phase[k] = PH_CHANGE;
  endtask

  task automatic model_step(input int k);
    m_acc[k] = 0;
    m_rej[k] = int'(cv[k]);
    case (m_phase[k])
      PH_INIT: begin
        m_credit[k] = 0;
        m_phase[k]  = PH_WAIT;
      end
      PH_WAIT: begin
        if (m_credit[k] >= PRICE) begin
          m_phase[k] = PH_VEND;
          m_idle[k]  = 0;
        end else if (cn[k] && m_credit[k] > 0) begin
          start_refund(k, m_credit[k]);
        end else if (cv[k] && cs[k] != 2'b00 &&
                     m_credit[k] + coin_val(int'(cs[k])) <= max_credit[k]) begin
          m_credit[k] += coin_val(int'(cs[k]));
          m_acc[k]  = 1;
          m_rej[k]  = 0;
          m_idle[k] = 0;
        end else if (m_credit[k] > 0 && m_idle[k] == idle_limit[k] - 1) begin
          start_refund(k, m_credit[k]);
        end else if (m_credit[k] > 0) begin
          m_idle[k]++;
        end else begin
          m_idle[k] = 0;
        end
      end
      PH_VEND: begin
        m_credit[k] -= PRICE;
        if (m_credit[k] > 0) start_refund(k, m_credit[k]);
        else m_phase[k] = PH_WAIT;
      end
      default: begin
        if (cr[k]) begin
          m_credit[k] -= coin_val(m_list[k][m_i[k]]);
          m_i[k]++;
          if (m_i[k] >= m_n[k]) m_phase[k] = PH_WAIT;
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_phase[k]  = PH_INIT;
        m_credit[k] = 0;
        m_idle[k]   = 0;
        m_acc[k]    = 0;
        m_rej[k]    = 0;
        m_n[k]      = 0;
        m_i[k]      = 0;
      end else begin
        model_step(k);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int exp_sel;
      exp_sel = (m_phase[k] == PH_CHANGE) ? m_list[k][m_i[k]] : 0;
      check($sformatf("i%0d.coin_accept", k), int'(d_acc[k]),    m_acc[k]);
      check($sformatf("i%0d.coin_reject", k), int'(d_rej[k]),    m_rej[k]);
      check($sformatf("i%0d.vend", k),        int'(d_vend[k]),   int'(m_phase[k] == PH_VEND));
      check($sformatf("i%0d.chg_valid", k),   int'(d_cvld[k]),   int'(m_phase[k] == PH_CHANGE));
      check($sformatf("i%0d.chg_sel", k),     int'(d_csel[k]),   exp_sel);
      check($sformatf("i%0d.credit", k),      int'(d_credit[k]), m_credit[k]);
      check($sformatf("i%0d.busy", k),        int'(d_busy[k]),   int'(m_phase[k] != PH_WAIT));
    end
  end

  // Drive one coin for one cycle; returns at the negedge where its accept/reject pulse shows.
  task automatic coin(input int k, input logic [1:0] c);
    cv[k] = 1'b1;
    cs[k] = c;
    @(negedge clk);
    cv[k] = 1'b0;
    cs[k] = 2'b00;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cv[k] = 1'b0; cs[k] = 2'b00; cn[k] = 1'b0; cr[k] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.busy",      int'(d_busy[0]),   1);
    check("rst.credit",    int'(d_credit[0]), 0);
    check("rst.chg_valid", int'(d_cvld[0]),   0);
    check("rst.chg_sel",   int'(d_csel[0]),   0);
    check("rst.vend",      int'(d_vend[0]),   0);
    check("rst.accept",    int'(d_acc[0]),    0);
    rst_n = 1'b1;
    @(negedge clk);
    check("init.to_wait", int'(d_busy[0]), 0);

    // Exact payment 50+20+10, a coin during the vend decision is rejected
    cr[0] = 1'b1;
    coin(0, 2'b11); check("exact.credit50", int'(d_credit[0]), 50);
    coin(0, 2'b10); check("exact.credit70", int'(d_credit[0]), 70);
    coin(0, 2'b01); check("exact.accept",   int'(d_acc[0]),    1);
    check("exact.credit80", int'(d_credit[0]), 80);
    coin(0, 2'b01);
    check("exact.vend",        int'(d_vend[0]),   1);
    check("exact.tie_reject",  int'(d_rej[0]),    1);
    @(negedge clk);
    check("exact.vend_once",   int'(d_vend[0]),   0);
    check("exact.credit0",     int'(d_credit[0]), 0);
    check("exact.no_change",   int'(d_cvld[0]),   0);

    // Overpayment 50+50 -> change 20
    coin(0, 2'b11);
    coin(0, 2'b11); check("over.credit100", int'(d_credit[0]), 100);
    @(negedge clk); check("over.vend", int'(d_vend[0]), 1);
    @(negedge clk);
    check("over.chg_valid", int'(d_cvld[0]),   1);
    check("over.chg_sel",   int'(d_csel[0]),   2);
    check("over.credit20",  int'(d_credit[0]), 20);
    @(negedge clk);
    check("over.done_valid",  int'(d_cvld[0]),   0);
    check("over.done_credit", int'(d_credit[0]), 0);

    // Handshake stall with a coin inserted during CHANGE
    cr[0] = 1'b0;
    coin(0, 2'b11);
    coin(0, 2'b11);
    repeat (2) @(negedge clk);
    check("stall.chg_valid", int'(d_cvld[0]), 1);
    coin(0, 2'b01);
    check("stall.reject", int'(d_rej[0]), 1);
    for (int i = 0; i < 4; i++) begin
      check("stall.hold_valid", int'(d_cvld[0]),   1);
      check("stall.hold_sel",   int'(d_csel[0]),   2);
      check("stall.hold_cred",  int'(d_credit[0]), 20);
      @(negedge clk);
    end
    cr[0] = 1'b1;
    @(negedge clk);
    check("stall.release", int'(d_cvld[0]),   0);
    check("stall.credit0", int'(d_credit[0]), 0);

    // Cancel 60 -> 50 then 10
    coin(0, 2'b11);
    coin(0, 2'b01);
    cn[0] = 1'b1;
    @(negedge clk);
    cn[0] = 1'b0;
    check("cancel.sel50",  int'(d_csel[0]),   3);
    check("cancel.cred60", int'(d_credit[0]), 60);
    @(negedge clk);
    check("cancel.sel10",  int'(d_csel[0]),   1);
    check("cancel.cred10", int'(d_credit[0]), 10);
    @(negedge clk);
    check("cancel.done", int'(d_cvld[0]), 0);

    // Cancel and coin in the same cycle
    coin(0, 2'b10);
    cn[0] = 1'b1;
    coin(0, 2'b11);
    cn[0] = 1'b0;
    check("cancoin.reject", int'(d_rej[0]),    1);
    check("cancoin.accept", int'(d_acc[0]),    0);
    check("cancoin.sel",    int'(d_csel[0]),   2);
    check("cancoin.credit", int'(d_credit[0]), 20);
    @(negedge clk);
    check("cancoin.done", int'(d_credit[0]), 0);

    // Ceiling 100 and invalid coin on the second instance
    cr[1] = 1'b1;
    coin(1, 2'b11);
    coin(1, 2'b10); check("ceil.credit70", int'(d_credit[1]), 70);
    coin(1, 2'b11);
    check("ceil.reject", int'(d_rej[1]),    1);
    check("ceil.keep70", int'(d_credit[1]), 70);
    coin(1, 2'b00);
    check("invalid.reject", int'(d_rej[1]),    1);
    check("invalid.keep70", int'(d_credit[1]), 70);
    cn[1] = 1'b1;
    @(negedge clk);
    cn[1] = 1'b0;
    check("ceil.refund50", int'(d_csel[1]), 3);
    @(negedge clk);
    check("ceil.refund20", int'(d_csel[1]), 2);
    @(negedge clk);
    check("ceil.cleared", int'(d_credit[1]), 0);

    // Inactivity timeout after 16 idle cycles
    cr[1] = 1'b0;
    coin(1, 2'b10);
    repeat (15) @(negedge clk);
    check("tmo.not_yet", int'(d_cvld[1]), 0);
    @(negedge clk);
    check("tmo.chg_valid", int'(d_cvld[1]),   1);
    check("tmo.chg_sel",   int'(d_csel[1]),   2);
    check("tmo.credit",    int'(d_credit[1]), 20);
    cr[1] = 1'b1;
    @(negedge clk);
    check("tmo.done", int'(d_credit[1]), 0);

    // Reset in the middle of CHANGE
    cr[1] = 1'b0;
    coin(1, 2'b10);
    cn[1] = 1'b1;
    @(negedge clk);
    cn[1] = 1'b0;
    check("rstchg.in_change", int'(d_cvld[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstchg.valid_drop", int'(d_cvld[1]),   0);
    check("rstchg.credit0",    int'(d_credit[1]), 0);
    check("rstchg.sel0",       int'(d_csel[1]),   0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstchg.init_busy", int'(d_busy[1]), 1);
    coin(1, 2'b01);
    check("rstchg.init_coin_rej", int'(d_rej[1]),    1);
    check("rstchg.wait",          int'(d_busy[1]),   0);
    check("rstchg.no_refund",     int'(d_credit[1]), 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
